// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: load-use bubbles, data-memory wait freeze, branch flush and a memory-latency watchdog.
// Optional build macro STALL_COUNTER_EN adds the stall_cnt_o statistics counter.
module hazard_stall_unit #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             exmem_memreq_i,
  input  logic             dmem_ready_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
`ifdef STALL_COUNTER_EN
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
`else
  output logic             mem_err_o
`endif
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_W = WCW'(TIMEOUT);
  localparam logic [WCW-1:0] ONE_W     = WCW'(1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_next;
  logic           mem_stall;
  logic           lu_hazard;

  if (TIMEOUT < 1 || CNT_W < 1) begin : g_bad_param
    $error("hazard_stall_unit: TIMEOUT and CNT_W must be at least 1");
  end

  assign mem_stall = exmem_memreq_i && !dmem_ready_i;
  assign lu_hazard = idex_memread_i && (idex_rt_i != 5'd0) &&
                     ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

  // Control outputs ignore FSM state; a branch seen during a bubble is
  // kept in ID and resolved again next cycle, so no flush then.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_hold_o   = 1'b0;
    if (!rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (mem_stall) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      pipe_hold_o  = 1'b1;
    end else if (lu_hazard) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  assign wait_next = (wait_cnt >= TIMEOUT_W) ? TIMEOUT_W : wait_cnt + ONE_W;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= ONE_W;
            if (ONE_W >= TIMEOUT_W) mem_err_o <= 1'b1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready_i || !exmem_memreq_i) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_next;
            if (wait_next >= TIMEOUT_W) mem_err_o <= 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef STALL_COUNTER_EN
  // Counts every edge on which the PC was held, wrapping naturally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (!pc_write_o) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed vectors push expectations, a negedge monitor pops and compares.
module tb_hazard_stall_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [4:0]  ifid_rs_i = '0;
  logic [4:0]  ifid_rt_i = '0;
  logic        idex_memread_i = 1'b0;
  logic [4:0]  idex_rt_i = '0;
  logic        exmem_memreq_i = 1'b0;
  logic        dmem_ready_i = 1'b1;
  logic        branch_taken_i = 1'b0;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic        pipe_hold_o;
  logic        mem_err_o;
  logic [31:0] stall_cnt_o;

  typedef struct {
    string       name;
    logic [4:0]  ctrl;
    logic        err;
    logic [31:0] stall;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] expStall = '0;

  hazard_stall_unit #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .exmem_memreq_i (exmem_memreq_i),
    .dmem_ready_i   (dmem_ready_i),
    .branch_taken_i (branch_taken_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .pipe_hold_o    (pipe_hold_o),
`ifdef STALL_COUNTER_EN
    .mem_err_o      (mem_err_o),
    .stall_cnt_o    (stall_cnt_o)
`else
    .mem_err_o      (mem_err_o)
`endif
  );

`ifndef STALL_COUNTER_EN
  assign stall_cnt_o = '0;
`endif

  always #5 clk_i = ~clk_i;

  // ctrl packs {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
  task automatic applyStimulus(input string name, input logic rst,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic memread, input logic [4:0] idrt,
                               input logic memreq, input logic ready,
                               input logic br, input logic [4:0] ctrl,
                               input logic err);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i          = rst;
    ifid_rs_i      = rs;
    ifid_rt_i      = rt;
    idex_memread_i = memread;
    idex_rt_i      = idrt;
    exmem_memreq_i = memreq;
    dmem_ready_i   = ready;
    branch_taken_i = br;
    if (!rst) expStall = '0;
    e.name  = name;
    e.ctrl  = ctrl;
    e.err   = err;
    e.stall = expStall;
    sb.push_back(e);
    if (rst && !ctrl[4]) expStall = expStall + 32'd1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [4:0] act;
    act = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o};
    checks++;
    if (act !== e.ctrl) begin
      failures++;
      $display("[TB] FAIL %s ctrl actual=%b required=%b", e.name, act, e.ctrl);
    end
    checks++;
    if (mem_err_o !== e.err) begin
      failures++;
      $display("[TB] FAIL %s mem_err actual=%b required=%b", e.name, mem_err_o, e.err);
    end
`ifdef STALL_COUNTER_EN
    checks++;
    if (stall_cnt_o !== e.stall) begin
      failures++;
      $display("[TB] FAIL %s stall_cnt actual=%0d required=%0d", e.name, stall_cnt_o, e.stall);
    end
`endif
  endtask

  always @(negedge clk_i) begin
    while (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    $display("[TB] start");
    applyStimulus("reset_idle",  0, 0, 0, 0, 0, 0, 1, 0, 5'b00010, 0);
    applyStimulus("reset_force", 0, 5, 0, 1, 5, 1, 0, 1, 5'b00010, 0);
    applyStimulus("idle",        1, 0, 0, 0, 0, 0, 1, 0, 5'b11000, 0);
    applyStimulus("lu_rs",       1, 5, 3, 1, 5, 0, 1, 0, 5'b00010, 0);
    applyStimulus("lu_cleared",  1, 5, 3, 0, 0, 1, 1, 0, 5'b11000, 0);
    applyStimulus("lu_rt_zero",  1, 0, 0, 1, 0, 0, 1, 0, 5'b11000, 0);
    applyStimulus("lu_rt",       1, 2, 7, 1, 7, 0, 1, 0, 5'b00010, 0);
    applyStimulus("branch",      1, 1, 2, 0, 0, 0, 1, 1, 5'b11100, 0);
    applyStimulus("lu_branch",   1, 5, 3, 1, 5, 0, 1, 1, 5'b00010, 0);
    applyStimulus("lu_br_mem",   1, 5, 3, 1, 5, 1, 0, 1, 5'b00001, 0);
    applyStimulus("mem_ready",   1, 0, 0, 0, 0, 1, 1, 0, 5'b11000, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("mem_wait",  1, 0, 0, 0, 0, 1, 0, 0, 5'b00001, 0);
    applyStimulus("mem_done",    1, 0, 0, 0, 0, 1, 1, 0, 5'b11000, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("b2b_wait",  1, 0, 0, 0, 0, 1, 0, 0, 5'b00001, 0);
    applyStimulus("b2b_ready",   1, 0, 0, 0, 0, 1, 1, 0, 5'b11000, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("b2b_wait2", 1, 0, 0, 0, 0, 1, 0, 0, 5'b00001, 0);
    applyStimulus("b2b_done",    1, 0, 0, 0, 0, 0, 1, 0, 5'b11000, 0);
    for (int i = 0; i < 6; i++)
      applyStimulus("wdog_wait", 1, 0, 0, 0, 0, 1, 0, 0, 5'b00001, (i >= 4) ? 1'b1 : 1'b0);
    applyStimulus("wdog_ready",  1, 0, 0, 0, 0, 1, 1, 0, 5'b11000, 1);
    applyStimulus("wdog_sticky", 1, 0, 0, 0, 0, 0, 1, 1, 5'b11100, 1);
    applyStimulus("wdog_clear",  0, 0, 0, 0, 0, 0, 1, 0, 5'b00010, 0);
    applyStimulus("post_reset",  1, 0, 0, 0, 0, 0, 1, 0, 5'b11000, 0);
    for (int i = 0; i < 2; i++)
      applyStimulus("pre_abort", 1, 0, 0, 0, 0, 1, 0, 0, 5'b00001, 0);
    applyStimulus("abort_rst",   0, 0, 0, 0, 0, 1, 0, 0, 5'b00010, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("after_abort", 1, 0, 0, 0, 0, 1, 0, 0, 5'b00001, 0);
    applyStimulus("abort_done",  1, 0, 0, 0, 0, 1, 1, 0, 5'b11000, 0);
    applyStimulus("final_idle",  1, 0, 0, 0, 0, 0, 1, 0, 5'b11000, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
